// File: rtl/detection_display_counter.sv
// BCD hit counter (0000-9999, sticky overflow) with a 4-digit multiplexed 7-segment driver.
// Optional feature: define DDC_SATURATE_EN to hold the count at 9999 instead of wrapping.
module detection_display_counter #(
  parameter int REFRESH_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        y,
  output logic [15:0] count_bcd,
  output logic        overflow,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  logic [15:0]          count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [REFRESH_W-1:0] refresh_q, refresh_d;
  logic [6:0]           seg_q, seg_d;
  logic [3:0]           an_q, an_d;
  logic [1:0]           sel_s;
  logic [3:0]           nibble_s;
  logic [16:0]          inc_s;

  // Digit-wise BCD increment; bit 16 is the carry out of the thousands digit.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
          c = 1'b1;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end else begin
        r[i*4 +: 4] = v[i*4 +: 4];
      end
    end
    return {c, r};
  endfunction

  // Active-low {g,f,e,d,c,b,a}; anything outside 0-9 is blanked.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  assign sel_s = refresh_q[REFRESH_W-1 -: 2];
  assign inc_s = bcd_inc(count_q);

  // Next-state for the hit counter and overflow flag: clear beats a hit.
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      count_d    = 16'h0000;
      overflow_d = 1'b0;
    end else if (y) begin
      if (count_q == 16'h9999) begin
`ifdef DDC_SATURATE_EN
        count_d = count_q;
`else
        count_d = 16'h0000;
`endif
        overflow_d = 1'b1;
      end else begin
        count_d = inc_s[15:0];
      end
    end else begin
      count_d = count_q;
    end
  end

  // Digit selection from the refresh counter; display follows the pre-edge state.
  always_comb begin
    refresh_d = refresh_q + {{(REFRESH_W-1){1'b0}}, 1'b1};
    nibble_s  = 4'd0;
    an_d      = 4'hF;
    case (sel_s)
      2'd0: begin nibble_s = count_q[3:0];   an_d = 4'b1110; end
      2'd1: begin nibble_s = count_q[7:4];   an_d = 4'b1101; end
      2'd2: begin nibble_s = count_q[11:8];  an_d = 4'b1011; end
      2'd3: begin nibble_s = count_q[15:12]; an_d = 4'b0111; end
      default: begin nibble_s = 4'd0; an_d = 4'hF; end
    endcase
    seg_d = seg_decode(nibble_s);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= 16'h0000;
      overflow_q <= 1'b0;
      refresh_q  <= '0;
      seg_q      <= 7'h7F;
      an_q       <= 4'hF;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
      refresh_q  <= refresh_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign count_bcd = count_q;
  assign overflow  = overflow_q;
  assign seg       = seg_q;
  assign an        = an_q;

endmodule
